// File: rtl/pattern_player.sv
// pattern_player: plays a programmed table of WIDTH-bit values onto pat_out.
// Each entry is held for hold+1 clocks. Playback can loop a fixed number of times or forever.
// Optional build macro PATTERN_PLAYER_FELL_FLAG_EN adds fell_lsb. This flag is a registered
// falling-edge marker for pat_out[0] and is cycle-aligned with pat_out.
module pattern_player #(
  parameter int                 WIDTH    = 4,
  parameter int                 DEPTH    = 8,
  parameter int                 HOLD_W   = 4,
  parameter logic [WIDTH-1:0]   IDLE_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [HOLD_W-1:0]          wr_hold,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic [7:0]                 loops,
  input  logic                       start,
  input  logic                       stop,
  output logic [WIDTH-1:0]           pat_out,
  output logic                       pat_valid,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic                       busy,
  output logic                       done
`ifdef PATTERN_PLAYER_FELL_FLAG_EN
  , output logic                     fell_lsb
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state;
  logic [WIDTH-1:0]    tbl_data [DEPTH];
  logic [HOLD_W-1:0]   tbl_hold [DEPTH];
  logic [AW:0]         len_q;
  logic [7:0]          loops_q;
  logic [7:0]          loop_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                start_ok;
  logic                step_end;
  logic                last_step;
  logic                more_loops;
  logic                finish;
  logic [AW-1:0]       next_idx;
  logic [WIDTH-1:0]    pat_next;

  // Table storage; not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      tbl_data[wr_addr] <= wr_data;
      tbl_hold[wr_addr] <= wr_hold;
    end
  end

  // Step/loop decisions and the value pat_out takes on the next edge.
  // pat_next is shared so the falling-edge flag sees exactly what the FSM loads.
  always_comb begin
    start_ok   = start && (len != '0) && (len <= LEN_MAX);
    step_end   = (hold_cnt == tbl_hold[step_idx]);
    last_step  = ((AW+1)'(step_idx) == len_q - (AW+1)'(1));
    more_loops = (loops_q == 8'd0) || ((loop_cnt + 8'd1) < loops_q);
    finish     = stop || (step_end && last_step && !more_loops);
    next_idx   = last_step ? '0 : step_idx + AW'(1);
    pat_next   = pat_out;
    case (state)
      IDLE: pat_next = start_ok ? tbl_data[0] : IDLE_VAL;
      PLAY: begin
        if (finish)        pat_next = IDLE_VAL;
        else if (step_end) pat_next = tbl_data[next_idx];
      end
      default: pat_next = IDLE_VAL;
    endcase
  end

  // Playback FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_out   <= IDLE_VAL;
      pat_valid <= 1'b0;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_q     <= '0;
      loops_q   <= '0;
      loop_cnt  <= '0;
      hold_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      pat_out <= pat_next;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= PLAY;
            len_q     <= len;
            loops_q   <= loops;
            loop_cnt  <= '0;
            hold_cnt  <= '0;
            step_idx  <= '0;
            pat_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PLAY: begin
          if (finish) begin
            state     <= IDLE;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            step_idx  <= '0;
            hold_cnt  <= '0;
            done      <= 1'b1;
          end else if (step_end) begin
            hold_cnt <= '0;
            step_idx <= next_idx;
            // Saturates so loops=0 (forever) never wraps the counter.
            if (last_step && loop_cnt != 8'hFF) loop_cnt <= loop_cnt + 8'd1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PATTERN_PLAYER_FELL_FLAG_EN
  // Falling edge of pat_out[0], aligned with the cycle pat_out shows the new value.
  always_ff @(posedge clk) begin
    if (rst) fell_lsb <= 1'b0;
    else     fell_lsb <= pat_out[0] & ~pat_next[0];
  end
`endif

endmodule

// File: tb/tb_pattern_player.sv
// Directed self-checking bench for pattern_player.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pattern_player;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 8;
  localparam int HOLD_W = 4;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [HOLD_W-1:0] wr_hold;
  logic [AW:0]       len;
  logic [7:0]        loops;
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  pat_out;
  logic              pat_valid;
  logic [AW-1:0]     step_idx;
  logic              busy;
  logic              done;
`ifdef PATTERN_PLAYER_FELL_FLAG_EN
  logic              fell_lsb;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pattern_player #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .IDLE_VAL(4'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_hold(wr_hold),
    .len(len), .loops(loops), .start(start), .stop(stop),
    .pat_out(pat_out), .pat_valid(pat_valid), .step_idx(step_idx),
    .busy(busy), .done(done)
`ifdef PATTERN_PLAYER_FELL_FLAG_EN
    , .fell_lsb(fell_lsb)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input int data, input int hold);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = WIDTH'(data);
    wr_hold = HOLD_W'(hold);
    tick();
    wr_en   = 1'b0;
  endtask

  // Leaves the bench in cycle 1 of the run (first value on pat_out).
  task automatic start_run(input int n, input int lp);
    start = 1'b1;
    len   = (AW+1)'(n);
    loops = 8'(lp);
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_pat"},   32'(pat_out),   32'h0);
    check({tag, "_valid"}, 32'(pat_valid), 32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
    check({tag, "_idx"},   32'(step_idx),  32'h0);
    check({tag, "_done"},  32'(done),      32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_hold = '0;
    len = '0; loops = '0; start = 1'b0; stop = 1'b0;
    #1;
    tick(); tick();
    check_idle("reset", 1'b0);
`ifdef PATTERN_PLAYER_FELL_FLAG_EN
    check("reset_fell", 32'(fell_lsb), 32'h0);
`endif
    rst = 1'b0;

    // Basic run: 4,5,4,5,4,5 with hold 0
    for (int i = 0; i < 6; i++) write_entry(i, (i % 2 == 0) ? 4 : 5, 0);
    start_run(6, 1);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("basic_pat_c%0d", c), 32'(pat_out), (c % 2 == 1) ? 32'h4 : 32'h5);
      check($sformatf("basic_idx_c%0d", c), 32'(step_idx), 32'(c - 1));
      check($sformatf("basic_busy_c%0d", c), 32'(busy), 32'h1);
      check($sformatf("basic_valid_c%0d", c), 32'(pat_valid), 32'h1);
      check($sformatf("basic_done_c%0d", c), 32'(done), 32'h0);
`ifdef PATTERN_PLAYER_FELL_FLAG_EN
      check($sformatf("basic_fell_c%0d", c), 32'(fell_lsb), (c == 3 || c == 5) ? 32'h1 : 32'h0);
`endif
      tick();
    end
    check_idle("basic_c7", 1'b1);
`ifdef PATTERN_PLAYER_FELL_FLAG_EN
    check("basic_fell_c7", 32'(fell_lsb), 32'h1);
`endif
    tick();
    check("basic_done_c8", 32'(done), 32'h0);

    // Hold: A for 4 cycles, 3 for 1; a start during PLAY is ignored
    write_entry(0, 4'hA, 3);
    write_entry(1, 4'h3, 0);
    start_run(2, 1);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("hold_pat_c%0d", c), 32'(pat_out), (c <= 4) ? 32'hA : 32'h3);
      check($sformatf("hold_idx_c%0d", c), 32'(step_idx), (c <= 4) ? 32'h0 : 32'h1);
      start = (c == 2);
      len   = 4'd1;
      tick();
    end
    start = 1'b0;
    check_idle("hold_c6", 1'b1);
    tick();

    // Looping: 1,2 three times
    write_entry(0, 1, 0);
    write_entry(1, 2, 0);
    start_run(2, 3);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("loop3_pat_c%0d", c), 32'(pat_out), (c % 2 == 1) ? 32'h1 : 32'h2);
      tick();
    end
    check_idle("loop3_c7", 1'b1);
    tick();

    // Loop forever, stopped in cycle 9
    start_run(2, 0);
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("loopinf_pat_c%0d", c), 32'(pat_out), (c % 2 == 1) ? 32'h1 : 32'h2);
      check($sformatf("loopinf_busy_c%0d", c), 32'(busy), 32'h1);
      stop = (c == 9);
      tick();
    end
    stop = 1'b0;
    check_idle("loopinf_c10", 1'b1);
    tick();

    // Invalid starts (len 0 and len > DEPTH) and stop in IDLE
    start_run(0, 1);
    check_idle("len0", 1'b0);
    start_run(9, 1);
    check_idle("len9", 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("stop_idle", 1'b0);

    // start+stop in IDLE: start wins
    stop = 1'b1;
    start_run(2, 1);
    stop = 1'b0;
    check("ss_busy_c1", 32'(busy), 32'h1);
    check("ss_pat_c1", 32'(pat_out), 32'h1);
    tick();
    check("ss_pat_c2", 32'(pat_out), 32'h2);
    tick();
    check("ss_done_c3", 32'(done), 32'h1);
    // start on the done cycle
    start_run(2, 1);
    check("b2b_busy", 32'(busy), 32'h1);
    check("b2b_pat_c1", 32'(pat_out), 32'h1);
    check("b2b_idx_c1", 32'(step_idx), 32'h0);
    // write during PLAY must be ignored
    write_entry(0, 4'hF, 0);
    check("b2b_pat_c2", 32'(pat_out), 32'h2);
    tick();
    check("b2b_done", 32'(done), 32'h1);
    tick();
    start_run(2, 1);
    check("wrplay_pat", 32'(pat_out), 32'h1);
    tick(); tick(); tick();

    // Reset mid-run, then replay unchanged table
    write_entry(0, 4, 0);
    write_entry(1, 5, 0);
    start_run(6, 1);
    tick(); tick();
    check("rstmid_pat_c3", 32'(pat_out), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rstmid_c4", 1'b0);
    start_run(6, 1);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("replay_pat_c%0d", c), 32'(pat_out), (c % 2 == 1) ? 32'h4 : 32'h5);
      tick();
    end
    check_idle("replay_c7", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
